// File: rtl/csa3_pipe_adder_if.sv
// csa3_pipe_adder_if: valid/ready operand and result bus for csa3_pipe_adder
// Signals: in_valid/in_ready/a/b/c/cin (operand side), out_valid/out_ready/out_sum (result side)
interface csa3_pipe_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] out_sum;
    modport master (
        output in_valid, a, b, c, cin, out_ready,
        input  in_ready, out_valid, out_sum
    );
    modport slave (
        input  in_valid, a, b, c, cin, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/csa3_pipe_adder.sv
// csa3_pipe_adder: a+b+c+cin via registered carry-save stage and NSEG-stage segmented carry-propagate pipeline
// Ports: clk; rst (async, active-high); bus (slave): in_valid/in_ready/a/b/c/cin in, out_valid/out_ready/out_sum out
module csa3_pipe_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input logic              clk,
    input logic              rst,
    csa3_pipe_adder_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;
    localparam int LF   = (NSEG - 1) * SEG;
    if (WIDTH % SEG != 0) begin : g_bad
        $error("csa3_pipe_adder: WIDTH must be a multiple of SEG");
    end
    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv && !rst;
    for (genvar k = 0; k < NSEG; k++) begin : st
        // xr/yr hold only the not-yet-added bits [WIDTH : k*SEG] of X/Y; p holds the finished low slices
        logic                 v;
        logic                 cy;
        logic [WIDTH+1:0]     p;
        logic [WIDTH-k*SEG:0] xr;
        logic [WIDTH-k*SEG:0] yr;
        if (k == 0) begin : g_csa
            assign p  = '0;
            assign cy = 1'b0;
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    v  <= 1'b0;
                    xr <= '0;
                    yr <= '0;
                end else if (adv) begin
                    v  <= bus.in_valid;
                    xr <= {1'b0, bus.a ^ bus.b ^ bus.c};
                    yr <= {(bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c), bus.cin};
                end
        end else begin : g_cpa
            localparam int LO = (k - 1) * SEG;
            logic [SEG:0]     t;
            logic [WIDTH+1:0] np;
            assign t = {1'b0, st[k-1].xr[SEG-1:0]} + {1'b0, st[k-1].yr[SEG-1:0]} + {{SEG{1'b0}}, st[k-1].cy};
            always_comb begin
                np            = st[k-1].p;
                np[LO +: SEG] = t[SEG-1:0];
            end
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    v  <= 1'b0;
                    cy <= 1'b0;
                    p  <= '0;
                    xr <= '0;
                    yr <= '0;
                end else if (adv) begin
                    v  <= st[k-1].v;
                    cy <= t[SEG];
                    p  <= np;
                    xr <= st[k-1].xr[WIDTH-LO:SEG];
                    yr <= st[k-1].yr[WIDTH-LO:SEG];
                end
        end
    end
    // last segment also folds in bit WIDTH of X/Y to form the two top sum bits
    logic [SEG:0]     tf;
    logic [1:0]       hf;
    logic [WIDTH+1:0] nf;
    assign tf = {1'b0, st[NSEG-1].xr[SEG-1:0]} + {1'b0, st[NSEG-1].yr[SEG-1:0]} + {{SEG{1'b0}}, st[NSEG-1].cy};
    assign hf = {1'b0, st[NSEG-1].xr[SEG]} + {1'b0, st[NSEG-1].yr[SEG]} + {1'b0, tf[SEG]};
    always_comb begin
        nf                   = st[NSEG-1].p;
        nf[LF +: SEG]        = tf[SEG-1:0];
        nf[WIDTH+1:WIDTH]    = hf;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
        end else if (adv) begin
            bus.out_valid <= st[NSEG-1].v;
            bus.out_sum   <= nf;
        end
endmodule

// File: tb/tb_csa3_pipe_adder.sv
// tb_csa3_pipe_adder: directed self-checking bench for csa3_pipe_adder at 64/16, 8/8 and 8/4
module tb_csa3_pipe_adder;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    always #5 clk = ~clk;

    csa3_pipe_adder_if #(.WIDTH(64)) i64 ();
    csa3_pipe_adder_if #(.WIDTH(8))  i8a ();
    csa3_pipe_adder_if #(.WIDTH(8))  i8b ();
    csa3_pipe_adder #(.WIDTH(64), .SEG(16)) d64 (.clk(clk), .rst(rst), .bus(i64.slave));
    csa3_pipe_adder #(.WIDTH(8),  .SEG(8))  d8a (.clk(clk), .rst(rst), .bus(i8a.slave));
    csa3_pipe_adder #(.WIDTH(8),  .SEG(4))  d8b (.clk(clk), .rst(rst), .bus(i8b.slave));

    logic [63:0] va [8] = '{64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h0000FFFF0000FFFF,
                            64'hDEADBEEFCAFEBABE, 64'h0, 64'h5555555555555555, 64'h000000000000FFFF};
    logic [63:0] vb [8] = '{64'hFEDCBA9876543210, 64'h0, 64'h8000000000000000, 64'h0000000100000001,
                            64'h1234567890ABCDEF, 64'h0, 64'hAAAAAAAAAAAAAAAA, 64'h000000000000FFFF};
    logic [63:0] vc [8] = '{64'h0F0F0F0F0F0F0F0F, 64'h0, 64'h8000000000000000, 64'hFFFF0000FFFF0000,
                            64'h0F1E2D3C4B5A6978, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h000000000000FFFF};
    logic        vci [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    function automatic logic [65:0] ref64(input int i);
        return {2'b0, va[i]} + {2'b0, vb[i]} + {2'b0, vc[i]} + {65'b0, vci[i]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        i64.in_valid = 0; i64.a = '0; i64.b = '0; i64.c = '0; i64.cin = 0; i64.out_ready = 1;
        i8a.in_valid = 0; i8a.a = '0; i8a.b = '0; i8a.c = '0; i8a.cin = 0; i8a.out_ready = 1;
        i8b.in_valid = 0; i8b.a = '0; i8b.b = '0; i8b.c = '0; i8b.cin = 0; i8b.out_ready = 1;
    endtask

    task automatic drive64(input int i);
        i64.in_valid = 1; i64.a = va[i]; i64.b = vb[i]; i64.c = vc[i]; i64.cin = vci[i];
    endtask

    task automatic run64(input logic [63:0] a, b, c, input logic ci, output int lat, output logic [65:0] sum);
        i64.in_valid = 1; i64.a = a; i64.b = b; i64.c = c; i64.cin = ci; i64.out_ready = 1;
        lat = -1;
        sum = '0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            step;
            i64.in_valid = 0;
            if (i64.out_valid) begin
                lat = n;
                sum = i64.out_sum;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        idle;
        #12;
        compared++;
        if (i64.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid64: got %b want 0", i64.out_valid); end
        compared++;
        if (i64.out_sum !== 66'h0) begin mismatched++; $display("FAIL reset_sum64: got %0h want 0", i64.out_sum); end
        compared++;
        if (i64.in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", i64.in_ready); end
        compared++;
        if ({i8a.out_valid, i8b.out_valid} !== 2'b00) begin
            mismatched++; $display("FAIL reset_valid8: got %b%b want 00", i8a.out_valid, i8b.out_valid);
        end
        @(negedge clk);
        rst = 0;
        step;
        compared++;
        if (i64.in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready: got %b want 1", i64.in_ready); end
        compared++;
        if (i64.out_valid !== 1'b0) begin mismatched++; $display("FAIL post_reset_valid: got %b want 0", i64.out_valid); end
    endtask

    task automatic test_max_vector;
        int lat;
        logic [65:0] sum;
        run64(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, lat, sum);
        compared++;
        if (lat != 5) begin mismatched++; $display("FAIL max_latency: got %0d want 5", lat); end
        compared++;
        if (sum !== 66'h2_FFFF_FFFF_FFFF_FFFE) begin mismatched++; $display("FAIL max_sum: got %0h want 2fffffffffffffffe", sum); end
    endtask

    task automatic test_ripple;
        int lat;
        logic [65:0] sum;
        run64(64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 1'b0, lat, sum);
        compared++;
        if (lat != 5) begin mismatched++; $display("FAIL ripple_latency: got %0d want 5", lat); end
        compared++;
        if (sum !== 66'h1_0000_0000_0000_0000) begin mismatched++; $display("FAIL ripple_sum: got %0h want 10000000000000000", sum); end
    endtask

    task automatic test_cin_only;
        int lat;
        logic [65:0] sum;
        run64(64'h0, 64'h0, 64'h0, 1'b1, lat, sum);
        compared++;
        if (lat != 5) begin mismatched++; $display("FAIL cin_latency: got %0d want 5", lat); end
        compared++;
        if (sum !== 66'h1) begin mismatched++; $display("FAIL cin_sum: got %0h want 1", sum); end
    endtask

    task automatic test_back_to_back;
        int rcv = 0;
        logic ev;
        idle;
        drive64(0);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step;
            ev = (cyc >= 5) && (cyc <= 12);
            compared++;
            if (i64.out_valid !== ev) begin mismatched++; $display("FAIL b2b_valid cyc %0d: got %b want %b", cyc, i64.out_valid, ev); end
            if (i64.out_valid && rcv < 8) begin
                compared++;
                if (i64.out_sum !== ref64(rcv)) begin
                    mismatched++; $display("FAIL b2b_sum[%0d]: got %0h want %0h", rcv, i64.out_sum, ref64(rcv));
                end
                rcv++;
            end
            if (cyc < 8) drive64(cyc);
            else i64.in_valid = 0;
        end
        compared++;
        if (rcv != 8) begin mismatched++; $display("FAIL b2b_count: got %0d want 8", rcv); end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int rcv = 0;
        int stall = 0;
        bit stalled = 0;
        logic [65:0] held = '0;
        idle;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            step;
            if (i64.out_valid && !stalled) begin
                stalled = 1;
                stall = 3;
            end
            i64.out_ready = (stall == 0);
            if (sent < 8) drive64(sent);
            else i64.in_valid = 0;
            #1;
            if (stall > 0) begin
                compared++;
                if (i64.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready stall %0d: got %b want 0", stall, i64.in_ready); end
                if (stall < 3) begin
                    compared++;
                    if (i64.out_sum !== held || i64.out_valid !== 1'b1) begin
                        mismatched++; $display("FAIL bp_hold: got %b/%0h want 1/%0h", i64.out_valid, i64.out_sum, held);
                    end
                end
                held = i64.out_sum;
                stall--;
            end
            if (i64.out_valid && i64.out_ready) begin
                compared++;
                if (i64.out_sum !== ref64(rcv)) begin
                    mismatched++; $display("FAIL bp_sum[%0d]: got %0h want %0h", rcv, i64.out_sum, ref64(rcv));
                end
                rcv++;
            end
            if (i64.in_valid && i64.in_ready) sent++;
        end
        compared++;
        if (rcv != 8 || sent != 8) begin mismatched++; $display("FAIL bp_count: got %0d/%0d want 8/8", rcv, sent); end
        compared++;
        if (!stalled) begin mismatched++; $display("FAIL bp_stall_seen: got 0 want 1"); end
        i64.in_valid = 0;
        i64.out_ready = 1;
        for (int n = 0; n < 3; n++) begin
            step;
            compared++;
            if (i64.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_extra: got %b want 0", i64.out_valid); end
        end
    endtask

    task automatic test_reset_inflight;
        int n = 0;
        idle;
        i64.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive64(i + 2);
            step;
        end
        i64.in_valid = 0;
        while (!i64.out_valid && n < 10) begin
            step;
            n++;
        end
        compared++;
        if (i64.out_valid !== 1'b1) begin mismatched++; $display("FAIL rst_pre_valid: got %b want 1", i64.out_valid); end
        #3;
        rst = 1;
        #1;
        compared++;
        if (i64.out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_async_valid: got %b want 0", i64.out_valid); end
        compared++;
        if (i64.out_sum !== 66'h0) begin mismatched++; $display("FAIL rst_async_sum: got %0h want 0", i64.out_sum); end
        compared++;
        if (i64.in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b want 0", i64.in_ready); end
        step;
        #2;
        rst = 0;
        i64.out_ready = 1;
        for (int k = 0; k < 12; k++) begin
            step;
            compared++;
            if (i64.out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_flush cyc %0d: got %b want 0", k, i64.out_valid); end
        end
    endtask

    task automatic test_small_widths;
        logic [7:0] ta [2] = '{8'hFF, 8'hFF};
        logic [7:0] tb [2] = '{8'hFF, 8'h01};
        logic [7:0] tc [2] = '{8'hFF, 8'h00};
        logic       tci [2] = '{1'b1, 1'b0};
        logic [9:0] te [2] = '{10'h2FE, 10'h100};
        int la, lb;
        logic [9:0] sa, sb;
        for (int v = 0; v < 2; v++) begin
            idle;
            i8a.in_valid = 1; i8a.a = ta[v]; i8a.b = tb[v]; i8a.c = tc[v]; i8a.cin = tci[v];
            i8b.in_valid = 1; i8b.a = ta[v]; i8b.b = tb[v]; i8b.c = tc[v]; i8b.cin = tci[v];
            la = -1; lb = -1; sa = '0; sb = '0;
            for (int n = 1; n <= 8; n++) begin
                step;
                i8a.in_valid = 0;
                i8b.in_valid = 0;
                if (i8a.out_valid && la < 0) begin la = n; sa = i8a.out_sum; end
                if (i8b.out_valid && lb < 0) begin lb = n; sb = i8b.out_sum; end
            end
            compared++;
            if (la != 2) begin mismatched++; $display("FAIL w8s8_latency[%0d]: got %0d want 2", v, la); end
            compared++;
            if (sa !== te[v]) begin mismatched++; $display("FAIL w8s8_sum[%0d]: got %0h want %0h", v, sa, te[v]); end
            compared++;
            if (lb != 3) begin mismatched++; $display("FAIL w8s4_latency[%0d]: got %0d want 3", v, lb); end
            compared++;
            if (sb !== te[v]) begin mismatched++; $display("FAIL w8s4_sum[%0d]: got %0h want %0h", v, sb, te[v]); end
        end
    endtask

    initial begin
        test_reset;
        test_max_vector;
        test_ripple;
        test_cin_only;
        test_back_to_back;
        test_backpressure;
        test_reset_inflight;
        test_small_widths;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/csa3_pipe_adder.md
Name: csa3_pipe_adder

Overview:
- Parametrised, pipelined successor to the 64-bit three-operand carry-save adder.
- Computes S = a + b + c + cin at WIDTH bits.
- Stage 1 is a registered carry-save compression stage. It is followed by a segmented, pipelined carry-propagate adder, one SEG-bit segment per cycle.
- Adds a valid/ready handshake with full-pipeline backpressure so it can sit directly in the MDCLCG datapath between the LCG state registers and downstream consumers.

Parameters:
- WIDTH, 64, operand width in bits. WIDTH % SEG must be 0; elaboration error otherwise.
- SEG, 16, carry-propagate segment width in bits. NSEG = WIDTH/SEG pipeline stages after the CSA stage.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept an input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- cin  input  1  carry-in, weight 2^0.
- out_valid  output  1  out_sum holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH+2  full unsigned sum a+b+c+cin; no truncation, no separate Cout.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits, out_valid and out_sum clear to 0.
  - in_ready is 0 while rst is high.
  - Any in-flight data is discarded; no result produced before reset remains visible afterwards.
- Global advance: adv = !out_valid || out_ready.
  - All pipeline registers load only when adv=1; otherwise every stage holds.
  - in_ready = adv (combinational from out_valid/out_ready, not from in_valid).
- Transfer rules:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
  - Accept and consume may occur in the same cycle; throughput is 1 result/cycle.
- Stage 0 (CSA), registered:
  - s = a^b^c.
  - cy = maj(a,b,c).
  - Vector X = {1'b0, s} (WIDTH+1 bits).
  - Vector Y = {cy, cin} (WIDTH+1 bits; cy shifted left one place, cin fills bit 0).
- Stages 1..NSEG (CPA): stage k (k=1..NSEG) adds bit slice [(k-1)*SEG +: SEG] of X and Y plus the carry registered from stage k-1.
  - Stage 1 carry-in is 0.
  - Not-yet-added upper slices are delayed in skew registers; completed lower slices are delayed in de-skew registers.
  - Stage NSEG additionally adds bit WIDTH of X and Y plus its own segment carry, producing out_sum[WIDTH+1:WIDTH].
- Latency: exactly L = 1 + NSEG clock edges from accept to out_valid=1, with no stalls. Each stall cycle adds one cycle.
- Ordering: results leave strictly in acceptance order. There is no reordering, duplication or loss under any out_ready pattern.
- Bubbles: bubbles (in_valid=0) propagate as valid=0 slots and are not collapsed.
- Stability: while out_valid=1 && out_ready=0, out_sum and out_valid remain constant.
- Width rule: the maximum sum 3(2^WIDTH-1)+1 fits in WIDTH+2 bits; out_sum[WIDTH+1] is set only for sums >= 2^(WIDTH+1).
- Boundary cases:
  - SEG=WIDTH gives L=2.
  - cin alone (a=b=c=0) gives out_sum=1.
  - A carry generated in segment 1 must ripple correctly through all NSEG stages.
- Reset mid-operation: out_valid falls in the same cycle rst rises, independent of clk.

Test Plan:
- WIDTH=64, SEG=16, accept a=b=c=0xFFFF_FFFF_FFFF_FFFF, cin=1, out_ready=1 -> out_valid exactly 5 cycles later, out_sum=0x2_FFFF_FFFF_FFFF_FFFE.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, c=0, cin=0 -> out_sum=0x1_0000_0000_0000_0000 (full-chain ripple); a=b=c=0, cin=1 -> out_sum=1.
- 8 back-to-back random vectors with in_valid=1, out_ready=1 -> 8 results on consecutive cycles 5..12, in order, each matching the reference model a+b+c+cin.
- Random stream with out_ready held low 3 cycles while out_valid=1 -> in_ready=0 for those cycles, out_sum held constant, all results delivered once and in order.
- Assert rst asynchronously with 3 results in flight -> out_valid=0 and out_sum=0 immediately; after release with in_valid=0, no output for at least 10 cycles.
- WIDTH=8, SEG=8: a=b=c=0xFF, cin=1 -> out_sum=0x2FE after 2 cycles. WIDTH=8, SEG=4: same vector -> out_sum=0x2FE after 3 cycles.
